// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the UART program loader.
//               The loader state machine and the UART receiver state enums,
//               the sync byte, and the 16-bit word-count type live here.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Loader protocol states
    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        LEN_LO    = 3'd1,
        LEN_HI    = 3'd2,
        DATA      = 3'd3,
        CHECK     = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    // UART receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Word count carried in the frame header (count_lo, count_hi)
    typedef logic [15:0] count_t;

    // True when the header asks for more words than the memory holds.
    // Memories with 2**16 or more words can take any 16-bit count.
    function automatic logic count_too_big(input count_t c, input int unsigned addr_w);
        if (addr_w >= 16) begin
            return 1'b0;
        end
        return (32'(c) > (32'd1 << addr_w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Instruction-memory write bus driven by the program loader.
//               master = loader side, slave = memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int N      = 32
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [N-1:0]      imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface
`default_nettype wire

// File: rtl/prog_loader_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first, idle high. Synchronizes rx,
//               qualifies the start bit at half a bit time, samples each
//               data bit mid-bit, and reports either a good byte or a
//               framing fault (stop bit low) as a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       rx,
    output logic [7:0]      rx_byte,
    output logic            byte_valid,
    output logic            frame_err
);

    localparam int CNT_W = ($clog2(CLKS_PER_BIT) > 0) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync;
    logic             prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    // Bit-timing state machine: start qualify, 8 data bits, stop check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            prev       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            prev       <= sync[1];
            case (state)
                RX_IDLE: begin
                    if (prev && !sync[1]) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A line that is high again mid-start was a glitch
                        state   <= sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shreg <= {sync[1], shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (sync[1]) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Loads a program image received over UART into instruction
//               memory and holds the core in reset until a load completes.
//               Frame: A5, count_lo, count_hi, count x 4 bytes (LE) words,
//               optional checksum byte.
//               Optional feature macro: PROG_LOADER_CHKSUM_EN - when defined,
//               a trailing XOR checksum byte over all data bytes is checked.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 8,
    parameter int N            = 32
) (
    input  wire logic          clk_div,
    input  wire logic          rst,
    input  wire logic          rx,
    prog_loader_if.master      imem,
    output logic               core_rst_n,
    output logic               done,
    output logic               error
);

    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        frame_err;

    state_t      state;
    count_t      count;       // words still to receive in DATA
    logic [1:0]  byte_idx;    // byte position within the current word
    logic [23:0] word;        // low three bytes of the word being assembled
    count_t      len;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]  chk;
`endif

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk_div),
        .rst_n      (rst),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign len = {rx_byte, count[7:0]};

    // Loader protocol FSM with registered memory-bus and status outputs
    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            state           <= WAIT_SYNC;
            count           <= '0;
            byte_idx        <= '0;
            word            <= '0;
            imem.imem_we    <= 1'b0;
            imem.imem_addr  <= '0;
            imem.imem_wdata <= '0;
            core_rst_n      <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
            chk             <= '0;
`endif
        end else begin
            imem.imem_we <= 1'b0;
            // Address advances in the cycle after each write strobe
            if (imem.imem_we) begin
                imem.imem_addr <= imem.imem_addr + 1'b1;
            end

            if (frame_err) begin
                // A completed or failed load ignores line noise
                if (state != DONE && state != ERROR) begin
                    state      <= ERROR;
                    error      <= 1'b1;
                    done       <= 1'b0;
                    core_rst_n <= 1'b0;
                end
            end else begin
                case (state)
                    WAIT_SYNC, DONE, ERROR: begin
                        if (byte_valid && rx_byte == SYNC_BYTE) begin
                            state          <= LEN_LO;
                            done           <= 1'b0;
                            error          <= 1'b0;
                            core_rst_n     <= 1'b0;
                            imem.imem_addr <= '0;
                            byte_idx       <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
                            chk            <= '0;
`endif
                        end
                    end
                    LEN_LO: begin
                        if (byte_valid) begin
                            count[7:0] <= rx_byte;
                            state      <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        if (byte_valid) begin
                            count <= len;
                            if (count_too_big(len, ADDR_W)) begin
                                state <= ERROR;
                                error <= 1'b1;
                            end else if (len == '0) begin
                                state <= CHECK;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (byte_valid) begin
`ifdef PROG_LOADER_CHKSUM_EN
                            chk      <= chk ^ rx_byte;
`endif
                            byte_idx <= byte_idx + 1'b1;
                            case (byte_idx)
                                2'd0: word[7:0]   <= rx_byte;
                                2'd1: word[15:8]  <= rx_byte;
                                2'd2: word[23:16] <= rx_byte;
                                default: begin
                                    imem.imem_we    <= 1'b1;
                                    imem.imem_wdata <= N'({rx_byte, word});
                                    if (count == 16'd1) begin
                                        state <= CHECK;
                                    end
                                    count <= count - 1'b1;
                                end
                            endcase
                        end
                    end
                    CHECK: begin
`ifdef PROG_LOADER_CHKSUM_EN
                        if (byte_valid) begin
                            if (rx_byte == chk) begin
                                state      <= DONE;
                                done       <= 1'b1;
                                core_rst_n <= 1'b1;
                            end else begin
                                state <= ERROR;
                                error <= 1'b1;
                            end
                        end
`else
                        state      <= DONE;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
`endif
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. Sends UART frames bit
//               by bit and compares memory writes and status against an
//               image-level model of what a frame should produce.
//               Honours PROG_LOADER_CHKSUM_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int CPB = 16;
    localparam int AW  = 8;
    localparam int NW  = 32;
`ifdef PROG_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk_div = 1'b0;
    logic rst     = 1'b0;
    logic rx      = 1'b1;
    logic core_rst_n;
    logic done;
    logic error;

    prog_loader_if #(.ADDR_W(AW), .N(NW)) bus ();

    prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .N            (NW)
    ) dut (
        .clk_div    (clk_div),
        .rst        (rst),
        .rx         (rx),
        .imem       (bus),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk_div = ~clk_div;

    int n_cmp = 0;
    int n_err = 0;

    // Every cycle with the strobe high is logged as one write {addr, data}
    logic [39:0] wr_q[$];
    always @(negedge clk_div) begin
        if (bus.imem_we === 1'b1) begin
            wr_q.push_back({bus.imem_addr, bus.imem_wdata});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk_div);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk_div);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk_div);
        rx = 1'b1;
        repeat ($urandom_range(2, 12)) @(negedge clk_div);
    endtask

    // Sends a complete frame; a header count above the memory depth is
    // followed by nothing, since the loader rejects it at the header.
    task automatic send_image(input logic [31:0] words[$], input int unsigned count, input bit bad_chk);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        wr_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(count[7:0], 1'b0);
        send_byte(count[15:8], 1'b0);
        if (count <= 256) begin
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) begin
                    b = words[i][8*k +: 8];
                    x = x ^ b;
                    send_byte(b, 1'b0);
                end
            end
            if (CHK_EN) begin
                send_byte(bad_chk ? ~x : x, 1'b0);
            end
        end
        repeat (20) @(negedge clk_div);
    endtask

    // Image-level expectation: words land at 0..count-1 when the count fits
    // in memory; success needs a fitting count and (if enabled) a good sum.
    task automatic expect_image(input string tag, input logic [31:0] words[$],
                                input int unsigned count, input bit bad_chk);
        bit          len_ok;
        bit          ok;
        int unsigned n_exp;
        logic [7:0]  a;
        len_ok = (count <= 256);
        ok     = len_ok && !(CHK_EN && bad_chk);
        n_exp  = len_ok ? words.size() : 0;
        check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
            a = 8'(i);
            check($sformatf("%s_wr%0d", tag, i), 64'(wr_q[i]), 64'({a, words[i]}));
        end
        check({tag, "_done"},       64'(done),       64'(ok));
        check({tag, "_error"},      64'(error),      64'(!ok));
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'(ok));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},         64'(bus.imem_we),    64'd0);
        check({tag, "_addr"},       64'(bus.imem_addr),  64'd0);
        check({tag, "_wdata"},      64'(bus.imem_wdata), 64'd0);
        check({tag, "_core_rst_n"}, 64'(core_rst_n),     64'd0);
        check({tag, "_done"},       64'(done),           64'd0);
        check({tag, "_error"},      64'(error),          64'd0);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] empty[$];
        int unsigned n;

        // Power-on reset
        repeat (3) @(negedge clk_div);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk_div);

        // Two-word image
        w = '{32'h00500013, 32'h00100093};
        send_image(w, 2, 1'b0);
        expect_image("two_words", w, 2, 1'b0);

        // Empty image
        send_image(empty, 0, 1'b0);
        expect_image("empty", empty, 0, 1'b0);

        // Count one past memory depth
        send_image(empty, 32'h0101, 1'b0);
        expect_image("too_long", empty, 32'h0101, 1'b0);

        // Exactly full memory is accepted (a single test of the boundary)
        w.delete();
        for (int i = 0; i < 256; i++) w.push_back($urandom);
        send_image(w, 256, 1'b0);
        expect_image("full_depth", w, 256, 1'b0);

`ifdef PROG_LOADER_CHKSUM_EN
        // Bad checksum, then a valid reload
        w = '{32'hDEADBEEF, 32'h12345678, 32'h0BADF00D};
        send_image(w, 3, 1'b1);
        expect_image("bad_chk", w, 3, 1'b1);
        send_image(w, 3, 1'b0);
        expect_image("reload", w, 3, 1'b0);
`endif

        // Random images
        for (int t = 0; t < 4; t++) begin
            w.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) w.push_back($urandom);
            send_image(w, n, 1'b0);
            expect_image($sformatf("rand%0d", t), w, n, 1'b0);
        end

        // Framing fault on the second data byte
        wr_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk_div);
        check("frame_err_error", 64'(error), 64'd1);
        check("frame_err_done", 64'(done), 64'd0);
        check("frame_err_core_rst_n", 64'(core_rst_n), 64'd0);
        check("frame_err_nwrites", 64'(wr_q.size()), 64'd0);

        // Recovery from ERROR with a fresh image
        w = '{32'hCAFEF00D};
        send_image(w, 1, 1'b0);
        expect_image("recover", w, 1, 1'b0);

        // Mid-word reset: two bytes of a word, then asynchronous reset
        wr_q.delete();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk_div);
        rst = 1'b1;
        repeat (3) @(negedge clk_div);

        // One-cycle low glitch while waiting for sync
        wr_q.delete();
        rx = 1'b0;
        @(negedge clk_div);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk_div);
        check("glitch_error", 64'(error), 64'd0);
        check("glitch_done", 64'(done), 64'd0);
        check("glitch_nwrites", 64'(wr_q.size()), 64'd0);

        // Post-reset image loads from address 0
        w = '{32'hA5A5A5A5, 32'h00000001, 32'hFFFFFFFF};
        send_image(w, 3, 1'b0);
        expect_image("after_reset", w, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
